// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and access sequencer for the data memory: legality checks,
// starvation protection and a locked-burst mode for requester 1, registered responses.
module dmem_arbiter #(
  parameter int MEM_BYTES = 4096,
  parameter int MAX_WAIT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [2:0]  m0_op,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [2:0]  m1_op,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_write_en,
  output logic [2:0]  mem_write_op,
  output logic [31:0] mem_write_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_read_en,
  output logic [2:0]  mem_read_op,
  output logic [31:0] mem_read_addr,
  input  logic [31:0] mem_read_data,
  output logic        o_dbg_state,
  output logic [3:0]  o_dbg_wait_cnt
);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_t;

  // Handshake: xN_gnt is the only acceptance; an accepted access always produces exactly
  // one xN_rvalid pulse in the following cycle, with xN_err/xN_rdata qualified by it.

  // Range is checked on the last byte in 33 bits so addresses near 2^32 cannot wrap to legal.
  function automatic logic f_legal(input logic we, input logic [2:0] op, input logic [31:0] addr);
    logic        op_ok;
    logic        align_ok;
    logic [32:0] last;
    logic [32:0] size_m1;
    op_ok = we ? (op == 3'b000 || op == 3'b001 || op == 3'b010)
               : (op == 3'b000 || op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b101);
    case (op[1:0])
      2'b01:   begin align_ok = ~addr[0];          size_m1 = 33'd1; end
      2'b10:   begin align_ok = (addr[1:0] == 2'b00); size_m1 = 33'd3; end
      default: begin align_ok = 1'b1;              size_m1 = 33'd0; end
    endcase
    last = {1'b0, addr} + size_m1;
    return op_ok & align_ok & (last < 33'(MEM_BYTES));
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_wait_cnt;
  logic        r_m0_rvalid, r_m0_err, r_m1_rvalid, r_m1_err;
  logic [31:0] r_m0_rdata, r_m1_rdata;
  logic        w_legal0, w_legal1, w_gnt0, w_gnt1, w_win_legal, w_win_we;
  logic [2:0]  w_win_op;
  logic [31:0] w_win_addr, w_win_wdata;

  assign w_legal0 = f_legal(m0_we, m0_op, m0_addr);
  assign w_legal1 = f_legal(m1_we, m1_op, m1_addr);

  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (m1_req && r_wait_cnt == 4'(MAX_WAIT)) w_gnt1 = 1'b1;
        else if (m0_req)                           w_gnt0 = 1'b1;
        else if (m1_req)                           w_gnt1 = 1'b1;
        if (w_gnt1 && m1_lock && w_legal1) w_state_nxt = ST_LOCK;
      end
      ST_LOCK: begin
        w_gnt1 = m1_req;
        if (!m1_req || !m1_lock || !w_legal1) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_win_legal = (w_gnt0 & w_legal0) | (w_gnt1 & w_legal1);
    w_win_we    = w_gnt1 ? m1_we    : m0_we;
    w_win_op    = w_gnt1 ? m1_op    : m0_op;
    w_win_addr  = w_gnt1 ? m1_addr  : m0_addr;
    w_win_wdata = w_gnt1 ? m1_wdata : m0_wdata;
  end

  assign m0_gnt         = w_gnt0;
  assign m1_gnt         = w_gnt1;
  assign mem_write_en   = w_win_legal & w_win_we;
  assign mem_read_en    = w_win_legal & ~w_win_we;
  assign mem_write_op   = w_win_legal ? w_win_op    : 3'b000;
  assign mem_read_op    = w_win_legal ? w_win_op    : 3'b000;
  assign mem_write_addr = w_win_legal ? w_win_addr  : 32'h0;
  assign mem_read_addr  = w_win_legal ? w_win_addr  : 32'h0;
  assign mem_write_data = w_win_legal ? w_win_wdata : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state != ST_LOCK) begin
        if (!m1_req || w_gnt1)                 r_wait_cnt <= 4'd0;
        else if (r_wait_cnt < 4'(MAX_WAIT))    r_wait_cnt <= r_wait_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m0_rvalid <= 1'b0;
      r_m0_err    <= 1'b0;
      r_m0_rdata  <= 32'h0;
      r_m1_rvalid <= 1'b0;
      r_m1_err    <= 1'b0;
      r_m1_rdata  <= 32'h0;
    end else begin
      r_m0_rvalid <= w_gnt0;
      r_m0_err    <= w_gnt0 & ~w_legal0;
      r_m0_rdata  <= (w_gnt0 & w_legal0 & ~m0_we) ? mem_read_data : 32'h0;
      r_m1_rvalid <= w_gnt1;
      r_m1_err    <= w_gnt1 & ~w_legal1;
      r_m1_rdata  <= (w_gnt1 & w_legal1 & ~m1_we) ? mem_read_data : 32'h0;
    end
  end

  assign m0_rvalid      = r_m0_rvalid;
  assign m0_err         = r_m0_err;
  assign m0_rdata       = r_m0_rdata;
  assign m1_rvalid      = r_m1_rvalid;
  assign m1_err         = r_m1_err;
  assign m1_rdata       = r_m1_rdata;
  assign o_dbg_state    = r_state;
  assign o_dbg_wait_cnt = r_wait_cnt;

endmodule
